// File: rtl/div_pkg.sv
// Shared state codes, widths and sign helper for the radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  localparam int          REG_W              = 32;
  localparam int          DREG_W             = 64;
  localparam logic        DIV_RESULT_READY     = 1'b1;
  localparam logic        DIV_RESULT_NOT_READY = 1'b0;
  localparam logic        DIV_START          = 1'b1;
  localparam logic [5:0]  DIV_ITERS          = 6'd32;

  function automatic logic [REG_W-1:0] neg_if(input logic c, input logic [REG_W-1:0] v);
    return c ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// 32-bit multi-cycle divider: unsigned restoring core, one quotient bit per clock,
// with sign magnitude conversion on entry and sign fixup on exit.
module div
  import div_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [REG_W-1:0]   opdata1_i,
  input  logic [REG_W-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [DREG_W-1:0]  result_o,
  output logic               ready_o
);

  div_state_t         r_state, w_state_nxt;
  logic [5:0]         r_cnt, w_cnt_nxt;
  logic [64:0]        r_work, w_work_nxt;
  logic [REG_W-1:0]   r_divisor, w_divisor_nxt;
  logic               r_signed, w_signed_nxt;
  logic               r_neg1, w_neg1_nxt;
  logic               r_neg2, w_neg2_nxt;
  logic [DREG_W-1:0]  r_result, w_result_nxt;
  logic               r_ready, w_ready_nxt;

  logic [REG_W:0]     w_diff;
  logic [REG_W-1:0]   w_op1_mag, w_op2_mag, w_quot, w_rem;
  logic               w_accept;

  assign w_accept  = (start_i == DIV_START) && !annul_i;
  assign w_op1_mag = neg_if(signed_div_i & opdata1_i[REG_W-1], opdata1_i);
  assign w_op2_mag = neg_if(signed_div_i & opdata2_i[REG_W-1], opdata2_i);
  assign w_diff    = {1'b0, r_work[63:32]} - {1'b0, r_divisor};
  // Quotient sign follows the operand sign mismatch; remainder takes the dividend's sign.
  assign w_quot    = neg_if(r_signed & (r_neg1 ^ r_neg2), r_work[31:0]);
  assign w_rem     = neg_if(r_signed & r_neg1, r_work[64:33]);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_signed_nxt  = r_signed;
    w_neg1_nxt    = r_neg1;
    w_neg2_nxt    = r_neg2;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;
    case (r_state)
      DIV_FREE: begin
        if (w_accept) begin
          if (opdata2_i == '0) begin
            w_state_nxt = DIV_BY_ZERO;
          end else begin
            w_state_nxt   = DIV_ON;
            w_cnt_nxt     = 6'd0;
            w_work_nxt    = {32'b0, w_op1_mag, 1'b0};
            w_divisor_nxt = w_op2_mag;
            w_signed_nxt  = signed_div_i;
            w_neg1_nxt    = opdata1_i[REG_W-1];
            w_neg2_nxt    = opdata2_i[REG_W-1];
          end
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i) begin
          w_state_nxt = DIV_FREE;
        end else begin
          w_state_nxt  = DIV_END;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          w_state_nxt = DIV_FREE;
          w_cnt_nxt   = 6'd0;
          w_ready_nxt = DIV_RESULT_NOT_READY;
        end else if (r_cnt == DIV_ITERS) begin
          w_state_nxt  = DIV_END;
          w_result_nxt = {w_rem, w_quot};
          w_ready_nxt  = DIV_RESULT_READY;
        end else begin
          if (w_diff[REG_W]) begin
            w_work_nxt = {r_work[63:0], 1'b0};
          end else begin
            w_work_nxt = {w_diff[31:0], r_work[31:0], 1'b1};
          end
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      DIV_END: begin
        if (!start_i) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= 6'd0;
      r_work    <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_result  <= '0;
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_signed  <= w_signed_nxt;
      r_neg1    <= w_neg1_nxt;
      r_neg2    <= w_neg2_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule
